mov8_sequencer: RTL and testbench
=================================

# mov8_sequencer

Register-to-register move sequencer that drives the select and load strobes of the 8-bit data bus. It accepts one MOV8 request (source code, destination code) at a time. It gates the source register onto the bus, waits for the relay contacts to settle, and pulses the destination load while the source is still driving. It then releases the bus in order and reports completion. It sits directly upstream of the data bus and is the only block permitted to assert data-bus selects or loads for register moves.

## Interface
Parameters:
- DATA_BUS_WIDTH, 8, width of the data bus snooped on data_in
- SETTLE_CYCLES, 2, cycles the source select is held before load asserts; legal range 1..15
- LOAD_CYCLES, 2, cycles load is held with the select; legal range 1..15

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  1  a move request is presented
- req_ready  output  1  sequencer can accept a request this cycle
- src  input  3  source code: 0 A, 1 B, 2 C, 3 D, 4 M1, 5 M2, 6 X, 7 Y
- dst  input  3  destination code, same encoding as src
- sel  output  8  one-hot source select; bit n corresponds to code n
- ld  output  8  one-hot destination load; bit n corresponds to code n
- data_in  input  DATA_BUS_WIDTH  data bus value as seen by the destination
- last_value  output  DATA_BUS_WIDTH  value written by the most recent completed move
- busy  output  1  a move is in progress
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, SELECT, LOAD, RELEASE, DONE. A down-counter times SELECT and LOAD.
- IDLE:
  - req_ready=1; busy=0; sel=0; ld=0.
  - On req_valid && req_ready, latch src and dst, load the counter with SETTLE_CYCLES-1, and go to SELECT.
- SELECT:
  - sel=onehot(src_q); ld=0.
  - When the counter reaches 0, load the counter with LOAD_CYCLES-1 and go to LOAD.
- LOAD:
  - sel=onehot(src_q); ld=onehot(dst_q).
  - When the counter reaches 0, capture last_value and go to RELEASE.
- RELEASE: sel=onehot(src_q); ld=0. Go to DONE unconditionally. This guarantees ld falls before sel.
- DONE: sel=0; ld=0; done=1. Go to IDLE.
- Self-move (src==dst), matching relay-machine clear semantics:
  - sel stays 0 for the whole sequence.
  - ld pulses exactly as for a normal move.
  - last_value captures 0 regardless of data_in.
- Request handling:
  - busy=1 in every state except IDLE.
  - req_ready=1 only in IDLE.
  - Requests presented while busy are ignored, not queued.
  - src and dst changes after acceptance are ignored.
- Output invariants:
  - sel and ld are never multi-hot.
  - ld is never asserted without the matching sel (except on a self-move).
- All outputs are registered or decoded purely from the state register and the latched codes. No combinational path exists from req_valid, src or dst to sel or ld.

## Timing
- Reset values: req_ready=1, busy=0, done=0, sel=0, ld=0, last_value=0, state IDLE, counter 0.
- Reset is asynchronous. Assertion mid-move clears sel and ld immediately, without waiting for a clock edge. The interrupted move never signals done, and last_value keeps its reset value of 0.
- Latency: let T be the accept edge (cycle 0).
  - sel asserts in cycle 1 and is held for SETTLE_CYCLES.
  - ld is active in cycles SETTLE_CYCLES+1 through SETTLE_CYCLES+LOAD_CYCLES.
  - RELEASE occupies cycle S+L+1, where S=SETTLE_CYCLES and L=LOAD_CYCLES.
  - done=1 in cycle S+L+2.
  - req_ready=1 again in cycle S+L+3.
- With default parameters the request-to-request period is 7 cycles:
  - sel active in cycles 1–5; ld active in cycles 3–4.
  - done in cycle 6; next accept possible at the edge ending cycle 7.
- last_value is sampled at the edge ending the final LOAD cycle and is visible from the RELEASE cycle onward.
- Back-to-back: a request held continuously is accepted at the first IDLE edge. The sequencer never produces an idle gap shorter than one cycle.

## Test plan
- Basic move (defaults): src=0 (A), dst=1 (B), data_in=8'h5A.
  - Expect sel=8'h01 in cycles 1–5 and ld=8'h02 in cycles 3–4.
  - Expect done in cycle 6 and last_value=8'h5A from cycle 5.
- Self-move: src=dst=3 (D), data_in=8'hFF.
  - Expect sel=0 throughout, ld=8'h08 in cycles 3–4, last_value=8'h00, done in cycle 6.
- Request while busy: accept a move of 6 to 7, then in cycle 2 drive req_valid=1 with src=2 and dst=4.
  - Expect no change to sel or ld and no second done.
  - The new request is accepted only after req_ready returns in cycle 7.
- Reset mid-LOAD: assert reset during cycle 3 of a 4-to-5 move.
  - Expect sel and ld to go to 0 before the next edge, and no done.
  - After release, expect req_ready=1 and last_value=0.
- Parameter sweep: SETTLE_CYCLES=1 with LOAD_CYCLES=1, then SETTLE_CYCLES=15 with LOAD_CYCLES=15.
  - Expect the done cycle at 4 and 32 respectively.
  - Expect ld to always fall one cycle before sel.
- Back-to-back, with req_valid held high: move 0 to 1, then move 1 to 2.
  - Expect the second accept at the end of cycle 7.
  - Expect the two sel windows to be separated by the DONE and IDLE cycles, with no overlap of one-hot outputs.

Source files
------------

// File: rtl/mov8_sequencer.sv
// mov8_sequencer: one-at-a-time register move sequencer driving one-hot data-bus selects and loads.
// Self-moves keep sel low and load zero, mirroring relay-machine clear semantics.
module mov8_sequencer #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                src,
  input  logic [2:0]                dst,
  output logic [7:0]                sel,
  output logic [7:0]                ld,
  input  logic [DATA_BUS_WIDTH-1:0] data_in,
  output logic [DATA_BUS_WIDTH-1:0] last_value,
  output logic                      busy,
  output logic                      done
);
  typedef enum logic [2:0] {IDLE, SELECT, LOAD, RELEASE, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [2:0] src_q, dst_q;
  logic self_move;
  assign self_move = src_q == dst_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      src_q <= '0;
      dst_q <= '0;
      last_value <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          src_q <= src;
          dst_q <= dst;
          cnt <= 4'(SETTLE_CYCLES - 1);
          state <= SELECT;
        end
        SELECT: if (cnt == 0) begin
          cnt <= 4'(LOAD_CYCLES - 1);
          state <= LOAD;
        end else cnt <= cnt - 4'd1;
        LOAD: if (cnt == 0) begin
          last_value <= self_move ? '0 : data_in;
          state <= RELEASE;
        end else cnt <= cnt - 4'd1;
        RELEASE: state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Decoded only from the state register, so async reset drops sel/ld at once.
  always_comb begin
    sel = (state inside {SELECT, LOAD, RELEASE} && !self_move) ? 8'b1 << src_q : '0;
    ld = (state == LOAD) ? 8'b1 << dst_q : '0;
    req_ready = state == IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
endmodule

// File: tb/tb_mov8_sequencer.sv
// tb_mov8_sequencer: three parameterisations driven in lockstep and checked against a timeline model.
module tb_mov8_sequencer;
  localparam int SP [3] = '{2, 1, 15};
  localparam int LP [3] = '{2, 1, 15};
  logic clk = 0, reset = 1, req_valid = 0;
  logic [2:0] src = 0, dst = 0;
  logic [7:0] data_in = 0;
  logic [2:0][7:0] sel_o, ld_o, lv_o;
  logic [2:0] ready_o, busy_o, done_o;
  int total = 0, bad = 0;
  int k [3];
  logic [2:0] ms [3], md [3];
  logic [7:0] lv [3];
  always #5 clk = ~clk;
  mov8_sequencer u0 (.clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_o[0]), .src(src), .dst(dst),
    .sel(sel_o[0]), .ld(ld_o[0]), .data_in(data_in), .last_value(lv_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  mov8_sequencer #(.SETTLE_CYCLES(1), .LOAD_CYCLES(1)) u1 (.clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(ready_o[1]), .src(src), .dst(dst), .sel(sel_o[1]), .ld(ld_o[1]), .data_in(data_in),
    .last_value(lv_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  mov8_sequencer #(.SETTLE_CYCLES(15), .LOAD_CYCLES(15)) u2 (.clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(ready_o[2]), .src(src), .dst(dst), .sel(sel_o[2]), .ld(ld_o[2]), .data_in(data_in),
    .last_value(lv_o[2]), .busy(busy_o[2]), .done(done_o[2]));
  // k = cycle number since the accept edge (accept edge ends cycle 0), -1 when idle.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        k[i] <= -1;
        lv[i] <= '0;
      end else if (k[i] < 0) begin
        if (req_valid) begin
          k[i] <= 1;
          ms[i] <= src;
          md[i] <= dst;
        end
      end else begin
        if (k[i] == SP[i] + LP[i]) lv[i] <= (ms[i] == md[i]) ? 8'h00 : data_in;
        k[i] <= (k[i] == SP[i] + LP[i] + 2) ? -1 : k[i] + 1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int s, l, c;
      s = SP[i];
      l = LP[i];
      c = k[i];
      chk($sformatf("u%0d_sel", i), 32'(sel_o[i]),
          (c >= 1 && c <= s + l + 1 && ms[i] != md[i]) ? 32'd1 << ms[i] : 32'd0);
      chk($sformatf("u%0d_ld", i), 32'(ld_o[i]), (c >= s + 1 && c <= s + l) ? 32'd1 << md[i] : 32'd0);
      chk($sformatf("u%0d_ready", i), 32'(ready_o[i]), 32'(c < 0));
      chk($sformatf("u%0d_busy", i), 32'(busy_o[i]), 32'(c >= 0));
      chk($sformatf("u%0d_done", i), 32'(done_o[i]), 32'(c == s + l + 2));
      chk($sformatf("u%0d_last", i), 32'(lv_o[i]), 32'(lv[i]));
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  task automatic idle(input int n);
    req_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    int d1, d2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("reset_ready", 32'(ready_o[0]), 32'd1);
    chk("reset_sel", 32'(sel_o[0]), 32'd0);
    chk("reset_last", 32'(lv_o[0]), 32'd0);
    check_all();
    // parameter sweep: done cycle of the 1/1 and 15/15 instances
    d1 = -1;
    d2 = -1;
    req_valid = 1; src = 0; dst = 1; data_in = 8'h33;
    for (int c = 1; c <= 40; c++) begin
      step();
      req_valid = 0;
      if (done_o[1] && d1 < 0) d1 = c;
      if (done_o[2] && d2 < 0) d2 = c;
    end
    chk("sweep_done_1_1", 32'(d1), 32'd4);
    chk("sweep_done_15_15", 32'(d2), 32'd32);
    // basic move A->B
    req_valid = 1; src = 0; dst = 1; data_in = 8'h5A;
    step();
    req_valid = 0;
    chk("basic_sel_c1", 32'(sel_o[0]), 32'h01);
    step(); step();
    chk("basic_ld_c3", 32'(ld_o[0]), 32'h02);
    step(); step();
    chk("basic_last_c5", 32'(lv_o[0]), 32'h5A);
    chk("basic_sel_c5", 32'(sel_o[0]), 32'h01);
    step();
    chk("basic_done_c6", 32'(done_o[0]), 32'd1);
    idle(2);
    // self-move D->D
    req_valid = 1; src = 3; dst = 3; data_in = 8'hFF;
    step();
    req_valid = 0;
    chk("self_sel_c1", 32'(sel_o[0]), 32'h00);
    step(); step();
    chk("self_ld_c3", 32'(ld_o[0]), 32'h08);
    step(); step();
    chk("self_last_c5", 32'(lv_o[0]), 32'h00);
    step();
    chk("self_done_c6", 32'(done_o[0]), 32'd1);
    idle(2);
    // request while busy
    req_valid = 1; src = 6; dst = 7; data_in = 8'h77;
    step();
    req_valid = 0;
    step();
    req_valid = 1; src = 2; dst = 4;
    step(); step();
    chk("busy_ld_c4", 32'(ld_o[0]), 32'h80);
    step(); step();
    chk("busy_done_c6", 32'(done_o[0]), 32'd1);
    step();
    chk("busy_ready_c7", 32'(ready_o[0]), 32'd1);
    step();
    chk("busy_sel_c8", 32'(sel_o[0]), 32'h04);
    idle(40);
    // back-to-back with req_valid held
    req_valid = 1; src = 0; dst = 1; data_in = 8'h11;
    step();
    src = 1; dst = 2;
    for (int c = 2; c <= 7; c++) begin
      step();
      if (c == 6) chk("b2b_done_c6", 32'(done_o[0]), 32'd1);
    end
    chk("b2b_sel_c7", 32'(sel_o[0]), 32'h00);
    chk("b2b_ready_c7", 32'(ready_o[0]), 32'd1);
    step();
    chk("b2b_sel_c8", 32'(sel_o[0]), 32'h02);
    idle(40);
    // reset mid-LOAD
    req_valid = 1; src = 4; dst = 5; data_in = 8'hC3;
    step();
    req_valid = 0;
    step(); step();
    chk("rst_ld_c3", 32'(ld_o[0]), 32'h20);
    #2 reset = 1;
    #1;
    chk("rst_sel_async", 32'(sel_o[0]), 32'h00);
    chk("rst_ld_async", 32'(ld_o[0]), 32'h00);
    @(negedge clk);
    reset = 0;
    check_all();
    for (int c = 0; c < 8; c++) begin
      step();
      chk("rst_no_done", 32'(done_o[0]), 32'd0);
    end
    chk("rst_ready", 32'(ready_o[0]), 32'd1);
    chk("rst_last", 32'(lv_o[0]), 32'd0);
    // randomized traffic with occasional async reset pulses
    for (int c = 0; c < 600; c++) begin
      req_valid = $urandom_range(0, 3) != 0;
      src = 3'($urandom);
      dst = ($urandom_range(0, 5) == 0) ? src : 3'($urandom);
      data_in = 8'($urandom);
      reset = $urandom_range(0, 63) == 0;
      step();
    end
    reset = 0;
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
